// File: rtl/peripheral_bus_controller.sv
// peripheral_bus_controller
// Serialises CPU peripheral requests onto the board I/O (switches, buttons,
// mono LEDs, seven-segment display word) one at a time. Also synchronises the
// switches, debounces the buttons and keeps sticky press events so the CPU
// only ever sees clean, race-free values.
module peripheral_bus_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock_100mhz,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    input  logic [4:0]  buttons_raw,
    input  logic [15:0] switches,
    output logic [15:0] mono_leds,
    output logic [31:0] display_word,
    output logic        display_override
);

    localparam int               NUM_BUTTONS = 5;
    localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_SWITCHES = 2'd0;
    localparam logic [1:0] ADDR_EVENTS   = 2'd1;
    localparam logic [1:0] ADDR_LEDS     = 2'd2;
    localparam logic [1:0] ADDR_DISPLAY  = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_next;

    logic                       accept;
    logic                       cap_write;
    logic [1:0]                 cap_addr;
    logic [31:0]                cap_wdata;

    logic [15:0]                sw_meta, sw_sync;
    logic [NUM_BUTTONS-1:0]     btn_meta, btn_sync, btn_level;
    logic [NUM_BUTTONS-1:0]     rise_pulse, event_latch, event_clear;
    logic [CNT_W-1:0]           db_cnt [NUM_BUTTONS];

    // Request sequencer state register.
    always_ff @(posedge clock_100mhz) begin
        // NOTE: all clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = reset_n;
                if (req_valid && reset_n) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    // Latch the accepted request so EXEC works from a stable copy.
    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // Bits returned by an event read are cleared in the same EXEC cycle.
    assign event_clear = (state == EXEC && !cap_write && cap_addr == ADDR_EVENTS)
                         ? event_latch : '0;

    // Perform the access in EXEC and hold the response until the next one.
    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            rsp_rdata        <= '0;
            rsp_error        <= 1'b0;
            mono_leds        <= '0;
            display_word     <= '0;
            display_override <= 1'b0;
        end else if (state == EXEC) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            if (cap_write) begin
                case (cap_addr)
                    ADDR_LEDS:    mono_leds <= cap_wdata[15:0];
                    ADDR_DISPLAY: begin
                        display_word     <= cap_wdata;
                        display_override <= 1'b1;
                    end
                    default:      rsp_error <= 1'b1;
                endcase
            end else begin
                case (cap_addr)
                    ADDR_SWITCHES: rsp_rdata <= {16'b0, sw_sync};
                    ADDR_EVENTS:   rsp_rdata <= {27'b0, event_latch};
                    ADDR_LEDS:     rsp_rdata <= {16'b0, mono_leds};
                    default:       rsp_rdata <= display_word;
                endcase
            end
        end
    end

    // Two-flop synchronisers for the asynchronous switches and buttons.
    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            btn_meta <= buttons_raw;
            btn_sync <= btn_meta;
        end
    end

    // Per-button debounce: level flips after DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            btn_level  <= '0;
            rise_pulse <= '0;
            // NOTE: the counter array is reset explicitly; it is a handful of
            // flops, and an unreset count would make the first press timing
            // depend on power-up contents.
            for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
        end else begin
            rise_pulse <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (btn_sync[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    btn_level[i]  <= btn_sync[i];
                    rise_pulse[i] <= btn_sync[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky press events; a set in the same cycle as a read-clear wins.
    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) event_latch <= '0;
        else          event_latch <= (event_latch & ~event_clear) | rise_pulse;
    end

endmodule
